serial_tx_unit: RTL

- Transmit end of the CPU's 2-bit serial bus. It consumes the TX command/data interface driven by the instruction decoder/scheduler and by the prefetcher, arbitrates between them, and serializes each transaction onto the tx pins.
- Returns the started/active/data_next/counter/done handshake those requesters expect.
- Tracks whether a reply is outstanding and holds off new transactions until the matching RX reply has arrived.

---
 rtl/serial_tx_unit_pkg.sv | 20 ++
 rtl/serial_tx_unit_tx_arbiter.sv | 61 ++++++
 rtl/serial_tx_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/serial_tx_unit_pkg.sv
// Shared definitions for the 2-bit serial bus transmitter: command layout,
// line symbols and serializer state encodings.
package serial_tx_unit_pkg;

    localparam int NSHIFT_DEF      = 2;
    localparam int TX_CMD_BITS_DEF = 2;
    localparam int LONG_BIT        = 1;

    // Start symbol is all ones on the pins, idle is all zeros.
    localparam logic START_BIT = 1'b1;
    localparam logic IDLE_BIT  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_CMD     = 2'd2,
        ST_PAYLOAD = 2'd3
    } tx_state_e;

endpackage

// File: rtl/serial_tx_unit_tx_arbiter.sv
// Scheduler/prefetch grant logic and the outstanding-reply flag that blocks
// new transactions until the RX side reports the reply.
module tx_arbiter
    import serial_tx_unit_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic bus_idle,
    input  logic sched_cmd_valid,
    input  logic sched_reply_wanted,
    input  logic sched_reserve,
    input  logic pf_cmd_valid,
    input  logic reply_received,
    output logic grant_sched,
    output logic grant_pf,
    output logic reply_pending
);

    logic reply_pending_r;
    logic want_reply_s;

    // Fixed priority: scheduler first, prefetch only when the bus is not reserved.
    always_comb begin
        grant_sched = 1'b0;
        grant_pf    = 1'b0;
        if (bus_idle && !reply_pending_r && !reset) begin
            if (sched_cmd_valid) begin
                grant_sched = 1'b1;
            end else if (pf_cmd_valid && !sched_reserve) begin
                grant_pf = 1'b1;
            end else begin
                grant_sched = 1'b0;
                grant_pf    = 1'b0;
            end
        end else begin
            grant_sched = 1'b0;
            grant_pf    = 1'b0;
        end
    end

    // Prefetch reads always expect a reply.
    always_comb begin
        want_reply_s = (grant_sched && sched_reply_wanted) || grant_pf;
    end

    // Reply flag: set by a reply-wanted grant, cleared by the RX completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reply_pending_r <= 1'b0;
        end else if (want_reply_s) begin
            reply_pending_r <= 1'b1;
        end else if (reply_received) begin
            reply_pending_r <= 1'b0;
        end else begin
            reply_pending_r <= reply_pending_r;
        end
    end

    assign reply_pending = reply_pending_r;

endmodule

// File: rtl/serial_tx_unit.sv
// Transmit end of the 2-bit serial bus: arbitrates scheduler and prefetch
// requests and serializes start, command and payload symbols onto tx_pins.
module serial_tx_unit
    import serial_tx_unit_pkg::*;
#(
    parameter int NSHIFT         = NSHIFT_DEF,
    parameter int PAYLOAD_CYCLES = 8,
    parameter int TX_CMD_BITS    = TX_CMD_BITS_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              sched_cmd_valid,
    input  logic [TX_CMD_BITS-1:0]            sched_cmd,
    input  logic                              sched_reply_wanted,
    input  logic                              sched_reserve,
    input  logic [NSHIFT-1:0]                 sched_data,
    output logic                              sched_started,
    input  logic                              pf_cmd_valid,
    input  logic [TX_CMD_BITS-1:0]            pf_cmd,
    input  logic [NSHIFT-1:0]                 pf_data,
    output logic                              pf_started,
    output logic                              tx_active,
    output logic                              tx_owner,
    output logic                              tx_data_next,
    output logic [$clog2(PAYLOAD_CYCLES):0]   tx_counter,
    output logic                              tx_done,
    output logic                              reply_pending,
    input  logic                              reply_received,
    output logic [NSHIFT-1:0]                 tx_pins
);

    localparam int CW = $clog2(PAYLOAD_CYCLES) + 1;

    tx_state_e              state_r;
    logic [TX_CMD_BITS-1:0] cmd_r;
    logic                   owner_r;
    logic [CW-1:0]          counter_r;
    logic [CW-1:0]          last_idx_s;
    logic                   grant_sched_s;
    logic                   grant_pf_s;

    tx_arbiter u_arbiter (
        .clk                (clk),
        .reset              (reset),
        .bus_idle           (state_r == ST_IDLE),
        .sched_cmd_valid    (sched_cmd_valid),
        .sched_reply_wanted (sched_reply_wanted),
        .sched_reserve      (sched_reserve),
        .pf_cmd_valid       (pf_cmd_valid),
        .reply_received     (reply_received),
        .grant_sched        (grant_sched_s),
        .grant_pf           (grant_pf_s),
        .reply_pending      (reply_pending)
    );

    assign sched_started = grant_sched_s;
    assign pf_started    = grant_pf_s;

    // Long commands carry two payload blocks.
    always_comb begin
        if (cmd_r[LONG_BIT]) begin
            last_idx_s = CW'(2 * PAYLOAD_CYCLES - 1);
        end else begin
            last_idx_s = CW'(PAYLOAD_CYCLES - 1);
        end
    end

    // Serializer FSM: IDLE -> START -> CMD -> PAYLOAD x L -> IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cmd_r     <= {TX_CMD_BITS{1'b0}};
            owner_r   <= 1'b0;
            counter_r <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_sched_s || grant_pf_s) begin
                        state_r <= ST_START;
                        cmd_r   <= grant_sched_s ? sched_cmd : pf_cmd;
                        owner_r <= grant_sched_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_START: begin
                    state_r <= ST_CMD;
                end
                ST_CMD: begin
                    state_r   <= ST_PAYLOAD;
                    counter_r <= {CW{1'b0}};
                end
                ST_PAYLOAD: begin
                    if (counter_r == last_idx_s) begin
                        state_r   <= ST_IDLE;
                        counter_r <= {CW{1'b0}};
                    end else begin
                        counter_r <= counter_r + CW'(1'b1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    counter_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Output decode; payload symbols pass straight from the owner's data input.
    always_comb begin
        tx_active    = (state_r != ST_IDLE);
        tx_owner     = owner_r;
        tx_data_next = (state_r == ST_PAYLOAD);
        tx_done      = (state_r == ST_PAYLOAD) && (counter_r == last_idx_s);
        tx_counter   = counter_r;
        case (state_r)
            ST_START:   tx_pins = {NSHIFT{START_BIT}};
            ST_CMD:     tx_pins = NSHIFT'(cmd_r);
            ST_PAYLOAD: tx_pins = owner_r ? sched_data : pf_data;
            default:    tx_pins = {NSHIFT{IDLE_BIT}};
        endcase
    end

endmodule
